nco_chan_cfg_ctrl: RTL

//  Configuration sequencer for the bank of CHANNEL_NUM polyphase NCO/mixer channels.
//  It accepts one per-sample tuning step through a valid/ready handshake and computes

---
 rtl/nco_chan_cfg_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nco_chan_cfg_ctrl.sv
// nco_chan_cfg_ctrl
//  Configuration sequencer for a bank of CHANNEL_NUM polyphase NCO/mixer channels.
//  Accepts a per-sample phase step over a valid/ready handshake and derives each
//  channel's initial phase (k*step) mod ACC_THRESHOLD plus the shared decimated step
//  (CHANNEL_NUM*step) mod ACC_THRESHOLD by repeated add-with-wrap (no multiplier).
//  The new values are then applied while every channel is held in reset.
//
// Ports
//  clk           system clock
//  srst          asynchronous reset, active-high
//  cfg_step      per-input-sample phase step, legal range 0..ACC_THRESHOLD-1
//  cfg_valid     cfg_step is valid
//  cfg_ready     idle, a request can be accepted
//  cfg_err       1-cycle pulse, out-of-range step dropped
//  cfg_done      1-cycle pulse, new configuration is live
//  step_real     shared step to all channels
//  adr_init_bus  channel k initial phase at [k*STEP_WIDTH +: STEP_WIDTH]
//  chan_srst     synchronous reset to all channels
module nco_chan_cfg_ctrl #(
  parameter int unsigned STEP_WIDTH    = 12,
  parameter int unsigned CHANNEL_NUM   = 8,
  parameter int unsigned ACC_THRESHOLD = 2400,
  parameter int unsigned SRST_CYCLES   = 2
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [STEP_WIDTH-1:0]             cfg_step,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  output logic                              cfg_err,
  output logic                              cfg_done,
  output logic [STEP_WIDTH-1:0]             step_real,
  output logic [CHANNEL_NUM*STEP_WIDTH-1:0] adr_init_bus,
  output logic                              chan_srst
);

  localparam int unsigned KW = $clog2(CHANNEL_NUM);
  localparam int unsigned CW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

  localparam logic [STEP_WIDTH:0] Thr     = (STEP_WIDTH+1)'(ACC_THRESHOLD);
  localparam logic [KW-1:0]       KLast   = KW'(CHANNEL_NUM - 1);
  localparam logic [CW-1:0]       CntLast = CW'(SRST_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StApply} state_e;

  state_e                              state_q, state_d;
  logic [STEP_WIDTH-1:0]               step_q, step_d;
  logic [STEP_WIDTH-1:0]               acc_q, acc_d;
  logic [KW-1:0]                       k_q, k_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [STEP_WIDTH-1:0]               shadow_q [CHANNEL_NUM];
  logic [STEP_WIDTH-1:0]               shadow_d [CHANNEL_NUM];
  logic                                ready_q, ready_d;
  logic                                err_q, err_d;
  logic                                done_q, done_d;
  logic [STEP_WIDTH-1:0]               step_real_q, step_real_d;
  logic [CHANNEL_NUM*STEP_WIDTH-1:0]   adr_q, adr_d;
  logic                                chan_srst_q, chan_srst_d;

  // One extra bit keeps acc+step from overflowing before the wrap compare.
  logic [STEP_WIDTH:0]                 acc_sum;
  logic [STEP_WIDTH:0]                 acc_wrap_full;
  logic [STEP_WIDTH-1:0]               acc_wrap;
  logic                                step_bad;

  always_comb begin
    acc_sum       = {1'b0, acc_q} + {1'b0, step_q};
    acc_wrap_full = (acc_sum >= Thr) ? (acc_sum - Thr) : acc_sum;
    acc_wrap      = acc_wrap_full[STEP_WIDTH-1:0];
    step_bad      = ({1'b0, cfg_step} >= Thr);
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    ready_d     = ready_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    step_real_d = step_real_q;
    adr_d       = adr_q;
    chan_srst_d = chan_srst_q;

    case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          if (step_bad) begin
            err_d = 1'b1;
          end else begin
            step_d  = cfg_step;
            acc_d   = '0;
            k_d     = '0;
            ready_d = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        shadow_d[k_q] = acc_q;
        acc_d         = acc_wrap;
        k_d           = k_q + KW'(1);
        if (k_q == KLast) begin
          // Last slot is written this same edge, so publish from the next-state copy.
          for (int i = 0; i < CHANNEL_NUM; i++) begin
            adr_d[i*STEP_WIDTH +: STEP_WIDTH] = shadow_d[i];
          end
          step_real_d = acc_wrap;
          chan_srst_d = 1'b1;
          cnt_d       = '0;
          state_d     = StApply;
        end
      end
      StApply: begin
        if (cnt_q == CntLast) begin
          chan_srst_d = 1'b0;
          done_d      = 1'b1;
          ready_d     = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= StIdle;
      step_q      <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        shadow_q[i] <= '0;
      end
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      step_real_q <= '0;
      adr_q       <= '0;
      chan_srst_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      ready_q     <= ready_d;
      err_q       <= err_d;
      done_q      <= done_d;
      step_real_q <= step_real_d;
      adr_q       <= adr_d;
      chan_srst_q <= chan_srst_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_err      = err_q;
  assign cfg_done     = done_q;
  assign step_real    = step_real_q;
  assign adr_init_bus = adr_q;
  assign chan_srst    = chan_srst_q;

endmodule
